// File: rtl/muldiv_if.sv
// Request, MTHI/MTLO, unit handshake and architectural register bundle for muldiv_ctrl.
// master = control FSM plus mult/div units, slave = the sequencer.
interface muldiv_if;
  logic        op_start;
  logic        op_kind;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        hi_wr;
  logic        lo_wr;
  logic [31:0] wr_data;
  logic [31:0] unit_a;
  logic [31:0] unit_b;
  logic        mult_start;
  logic        div_start;
  logic        mult_end;
  logic        div_end;
  logic [31:0] mult_hi;
  logic [31:0] mult_lo;
  logic [31:0] div_hi;
  logic [31:0] div_lo;
  logic        div_0_exception;
  logic [31:0] HI;
  logic [31:0] LO;
  logic        busy;
  logic        done;
  logic        div0_exc;
  logic        timeout_err;

  modport master (
    output op_start, op_kind, op_a, op_b, hi_wr, lo_wr, wr_data,
    output mult_end, div_end, mult_hi, mult_lo, div_hi, div_lo, div_0_exception,
    input  unit_a, unit_b, mult_start, div_start,
    input  HI, LO, busy, done, div0_exc, timeout_err
  );

  modport slave (
    input  op_start, op_kind, op_a, op_b, hi_wr, lo_wr, wr_data,
    input  mult_end, div_end, mult_hi, mult_lo, div_hi, div_lo, div_0_exception,
    output unit_a, unit_b, mult_start, div_start,
    output HI, LO, busy, done, div0_exc, timeout_err
  );
endinterface

// File: rtl/muldiv_ctrl.sv
// Sequencer for the multi-cycle mult/div units: zero-divisor precheck, launch,
// watchdog-guarded wait, and ownership of the architectural HI/LO registers.
module muldiv_ctrl #(
  parameter int TIMEOUT = 40
) (
  input logic     clock,
  input logic     reset,
  muldiv_if.slave bus
);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, LAUNCH, WAIT, DONE, DIV0, ERR
  } state_t;

  state_t        state_reg, state_next;
  logic          kind_reg, kind_next;
  logic [31:0]   unit_a_reg, unit_a_next;
  logic [31:0]   unit_b_reg, unit_b_next;
  logic [31:0]   hi_reg, hi_next;
  logic [31:0]   lo_reg, lo_next;
  logic [CW-1:0] cnt_reg, cnt_next;

  logic          sel_end;
  logic [31:0]   sel_hi;
  logic [31:0]   sel_lo;

  // Only the unit that was launched is listened to; the other is ignored.
  assign sel_end = kind_reg ? bus.div_end : bus.mult_end;
  assign sel_hi  = kind_reg ? bus.div_hi  : bus.mult_hi;
  assign sel_lo  = kind_reg ? bus.div_lo  : bus.mult_lo;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg  <= IDLE;
      kind_reg   <= 1'b0;
      unit_a_reg <= '0;
      unit_b_reg <= '0;
      hi_reg     <= '0;
      lo_reg     <= '0;
      cnt_reg    <= '0;
    end else begin
      state_reg  <= state_next;
      kind_reg   <= kind_next;
      unit_a_reg <= unit_a_next;
      unit_b_reg <= unit_b_next;
      hi_reg     <= hi_next;
      lo_reg     <= lo_next;
      cnt_reg    <= cnt_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    kind_next   = kind_reg;
    unit_a_next = unit_a_reg;
    unit_b_next = unit_b_reg;
    hi_next     = hi_reg;
    lo_next     = lo_reg;
    cnt_next    = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (bus.op_start) begin
          // A pending request takes precedence over MTHI/MTLO in the same cycle.
          if (bus.op_kind && (bus.op_b == 32'd0)) begin
            state_next = DIV0;
          end else begin
            kind_next   = bus.op_kind;
            unit_a_next = bus.op_a;
            unit_b_next = bus.op_b;
            state_next  = LAUNCH;
          end
        end else begin
          if (bus.hi_wr) hi_next = bus.wr_data;
          if (bus.lo_wr) lo_next = bus.wr_data;
        end
      end
      LAUNCH: begin
        cnt_next   = '0;
        state_next = WAIT;
      end
      WAIT: begin
        // Completion in the final watchdog cycle still wins over the timeout.
        if (sel_end) begin
          if (kind_reg && bus.div_0_exception) begin
            state_next = DIV0;
          end else begin
            hi_next    = sel_hi;
            lo_next    = sel_lo;
            state_next = DONE;
          end
        end else if (cnt_reg == CNT_LAST) begin
          state_next = ERR;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      DONE, DIV0, ERR: state_next = IDLE;
      default:         state_next = IDLE;
    endcase
  end

  assign bus.unit_a      = unit_a_reg;
  assign bus.unit_b      = unit_b_reg;
  assign bus.HI          = hi_reg;
  assign bus.LO          = lo_reg;
  assign bus.mult_start  = (state_reg == LAUNCH) && !kind_reg;
  assign bus.div_start   = (state_reg == LAUNCH) &&  kind_reg;
  assign bus.busy        = (state_reg != IDLE);
  assign bus.done        = (state_reg == DONE);
  assign bus.div0_exc    = (state_reg == DIV0);
  assign bus.timeout_err = (state_reg == ERR);
endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Sequencer for the multi-cycle multiply and divide units. It accepts one MULT or DIV request from the main control unit and checks for divide-by-zero before launching anything. It then pulses the selected unit's start, waits for its end under a watchdog, and commits the result into the architectural HI/LO registers it owns. It sits between the control FSM and the Mult/Div datapath blocks, and also services MTHI/MTLO writes.

## Interface
- TIMEOUT, 40: maximum WAIT cycles before a unit is declared hung (≥2).
- clock  in  1  system clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high; sampled on clock rising edge.
- op_start  in  1  request; sampled only in IDLE.
- op_kind  in  1  0 = MULT, 1 = DIV.
- op_a, op_b  in  32  operands (rs, rt); sampled with op_start.
- hi_wr, lo_wr  in  1  MTHI/MTLO strobes; honoured only in IDLE.
- wr_data  in  32  MTHI/MTLO data.
- unit_a, unit_b  out  32  latched operands, held stable from LAUNCH through WAIT.
- mult_start, div_start  out  1  one-cycle launch pulses.
- mult_end, div_end  in  1  unit completion.
- mult_hi, mult_lo, div_hi, div_lo  in  32  unit results, valid with the matching end signal.
- div_0_exception  in  1  divider-reported zero divisor, valid with div_end.
- HI, LO  out  32  architectural registers.
- busy  out  1  high whenever state ≠ IDLE.
- done  out  1  one-cycle pulse: result committed.
- div0_exc  out  1  one-cycle pulse: divide by zero.
- timeout_err  out  1  one-cycle pulse: watchdog expired.

## Operation
- States: IDLE, LAUNCH, WAIT, DONE, DIV0, ERR.
- IDLE, op_start=1, op_kind=1, op_b=0:
  - Go to DIV0. No unit is started.
- IDLE, any other op_start=1:
  - Latch op_a/op_b into unit_a/unit_b and latch op_kind.
  - Go to LAUNCH.
- IDLE, no op_start:
  - hi_wr → HI<=wr_data; lo_wr → LO<=wr_data. Both may occur in the same cycle.
  - If op_start and hi_wr/lo_wr are asserted together, op_start wins and the writes are dropped.
- LAUNCH:
  - Assert the selected start (mult_start or div_start) for exactly this cycle.
  - Clear the watchdog counter. Go to WAIT.
  - An end asserted during LAUNCH is ignored.
- WAIT, selected end=1:
  - DIV with div_0_exception=1: go to DIV0. HI/LO unchanged.
  - Otherwise: HI<=sel_hi, LO<=sel_lo, then go to DONE.
  - The controller passes results through unmodified: for DIV, HI = remainder and LO = quotient as delivered by the divider.
- WAIT, no end: counter++. If the counter reaches TIMEOUT-1 with no end, go to ERR.
- The non-selected unit's end and results are ignored throughout.
- DONE / DIV0 / ERR: assert done / div0_exc / timeout_err for that single cycle, then return to IDLE.
- op_start, hi_wr and lo_wr outside IDLE are ignored. The requester holds the request while busy=1.
- Reset at any cycle, including mid-WAIT, applies all reset values at the next edge and returns to IDLE.
  - Any unit still running is abandoned; its later end is ignored because the state is IDLE.

## Timing
- Reset values: HI=LO=0, unit_a=unit_b=0, mult_start=div_start=0, busy=done=div0_exc=timeout_err=0, state IDLE, counter 0.
- Normal operation (op_start sampled at edge 0):
  - LAUNCH is cycle 1, with start high.
  - If the unit asserts end in cycle 1+N (N≥1), HI/LO update at the end of that cycle.
  - done is high in cycle 2+N.
  - busy is high from cycle 1 through the done cycle.
  - Next op_start is accepted in cycle 3+N.
- Zero divisor: DIV0 is cycle 1 with div0_exc=1 and busy=1; IDLE resumes in cycle 2.
- Timeout: WAIT lasts at most TIMEOUT cycles (cycles 2..TIMEOUT+1); ERR is cycle TIMEOUT+2.
  - If end arrives in the last WAIT cycle, normal completion takes priority over timeout.
- Every pulse output is exactly one cycle wide. done, div0_exc and timeout_err are mutually exclusive.
- MTHI/MTLO in IDLE: HI/LO visible the cycle after the strobe.

## Test plan
- MULT, op_a=7, op_b=0xFFFFFFFD; unit model returns end after 33 cycles with HI=0xFFFFFFFF, LO=0xFFFFFFEB.
  - Required: mult_start only in cycle 1.
  - Required: HI/LO match the model, done in cycle 35, busy cycles 1-35.
- DIV, op_a=100, op_b=7; model returns HI=2, LO=14.
  - Required: div_start pulses once and mult_start never does.
  - Required: done pulses and HI=2, LO=14.
  - Required: a spurious mult_end during WAIT has no effect.
- DIV with op_b=0 after MTHI 0xAAAA0000 / MTLO 0x5555:
  - Required: no div_start, div0_exc in cycle 1, HI/LO unchanged.
  - Then a divider model raising div_0_exception with div_end: div0_exc pulses and HI/LO are unchanged.
- Unit never asserts end, TIMEOUT=40:
  - Required: timeout_err in cycle 42 only, HI/LO unchanged, IDLE in cycle 43.
  - Repeat with end in cycle 41: required done, not timeout_err.
- hi_wr during WAIT is dropped.
- op_start together with lo_wr in IDLE: the op is accepted and LO is unchanged.
- Reset asserted mid-WAIT:
  - Required: all outputs are at their reset values the next cycle.
  - Required: the late unit end is ignored, and a new op is accepted normally.
